// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed seven-segment driver.
// Holds the active-low glyph constants {a,b,c,d,e,f,g}, the nibble-to-glyph
// decoder and the conversion FSM state type.
package seg7_pkg;

  localparam int unsigned SEG_W = 7;
  localparam int unsigned NIB_W = 4;

  localparam logic [SEG_W-1:0] GLYPH_0     = 7'b0000001;
  localparam logic [SEG_W-1:0] GLYPH_1     = 7'b1001111;
  localparam logic [SEG_W-1:0] GLYPH_2     = 7'b0010010;
  localparam logic [SEG_W-1:0] GLYPH_3     = 7'b0000110;
  localparam logic [SEG_W-1:0] GLYPH_4     = 7'b1001100;
  localparam logic [SEG_W-1:0] GLYPH_5     = 7'b0100100;
  localparam logic [SEG_W-1:0] GLYPH_6     = 7'b0100000;
  localparam logic [SEG_W-1:0] GLYPH_7     = 7'b0001111;
  localparam logic [SEG_W-1:0] GLYPH_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] GLYPH_9     = 7'b0000100;
  localparam logic [SEG_W-1:0] GLYPH_A     = 7'b0001000;
  localparam logic [SEG_W-1:0] GLYPH_B     = 7'b1100000;
  localparam logic [SEG_W-1:0] GLYPH_C     = 7'b0110001;
  localparam logic [SEG_W-1:0] GLYPH_D     = 7'b1000010;
  localparam logic [SEG_W-1:0] GLYPH_E     = 7'b0110000;
  localparam logic [SEG_W-1:0] GLYPH_F     = 7'b0111000;
  localparam logic [SEG_W-1:0] GLYPH_DASH  = 7'b1111110;
  localparam logic [SEG_W-1:0] GLYPH_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_LATCH
  } conv_state_e;

  // Decimal digits above 9 never come out of the converter; show "0" if one does.
  function automatic logic [SEG_W-1:0] nib2glyph(input logic [NIB_W-1:0] nib,
                                                 input logic hex);
    logic [SEG_W-1:0] g;
    g = GLYPH_0;
    case (nib)
      4'h1:    g = GLYPH_1;
      4'h2:    g = GLYPH_2;
      4'h3:    g = GLYPH_3;
      4'h4:    g = GLYPH_4;
      4'h5:    g = GLYPH_5;
      4'h6:    g = GLYPH_6;
      4'h7:    g = GLYPH_7;
      4'h8:    g = GLYPH_8;
      4'h9:    g = GLYPH_9;
      4'hA:    g = GLYPH_A;
      4'hB:    g = GLYPH_B;
      4'hC:    g = GLYPH_C;
      4'hD:    g = GLYPH_D;
      4'hE:    g = GLYPH_E;
      4'hF:    g = GLYPH_F;
      default: g = GLYPH_0;
    endcase
    if (!hex && (nib > 4'd9)) begin
      g = GLYPH_0;
    end
    return g;
  endfunction

endpackage

// File: rtl/seq_bin2bcd.sv
// Sequential shift-add-3 binary to BCD/hex converter, reconverting continuously.
// Ports:
//   clk, rst      clock, async active-high reset
//   num_i         binary value, sampled once per conversion in IDLE
//   hex_mode_i    1 = hex nibbles (add-3 bypassed), sampled with num_i
//   disp_o        display register, one nibble per digit, updated atomically
//   disp_hex_o    mode the display register was converted in
//   overflow_o    last conversion lost a 1 off the top of the accumulator
//   conv_done_o   one-cycle pulse when disp_o updates
module seq_bin2bcd #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned BIN_W      = 13
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [BIN_W-1:0]        num_i,
  input  logic                    hex_mode_i,
  output logic [4*NUM_DIGITS-1:0] disp_o,
  output logic                    disp_hex_o,
  output logic                    overflow_o,
  output logic                    conv_done_o
);
  import seg7_pkg::*;

  localparam int unsigned ACC_W = 4 * NUM_DIGITS;
  localparam int unsigned CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  conv_state_e      state_q, state_d;
  logic [BIN_W-1:0] sr_q, sr_d;
  logic [ACC_W-1:0] acc_q, acc_d, adj;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hex_q, hex_d;
  logic             sticky_q, sticky_d;
  logic [ACC_W-1:0] disp_q, disp_d;
  logic             disp_hex_q, disp_hex_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      sr_q       <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      hex_q      <= 1'b0;
      sticky_q   <= 1'b0;
      disp_q     <= '0;
      disp_hex_q <= 1'b0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      hex_q      <= hex_d;
      sticky_q   <= sticky_d;
      disp_q     <= disp_d;
      disp_hex_q <= disp_hex_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
    end
  end

  // Add-3 correction on every nibble >= 5 (decimal only).
  always_comb begin
    adj = acc_q;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (!hex_q && (acc_q[4*d +: 4] >= 4'd5)) begin
        adj[4*d +: 4] = acc_q[4*d +: 4] + 4'd3;
      end
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    hex_d      = hex_q;
    sticky_d   = sticky_q;
    disp_d     = disp_q;
    disp_hex_d = disp_hex_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        sr_d     = num_i;
        hex_d    = hex_mode_i;
        acc_d    = '0;
        sticky_d = 1'b0;
        cnt_d    = '0;
        state_d  = ST_SHIFT;
      end
      ST_SHIFT: begin
        acc_d    = {adj[ACC_W-2:0], sr_q[BIN_W-1]};
        sr_d     = sr_q << 1;
        sticky_d = sticky_q | adj[ACC_W-1];
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          state_d = ST_LATCH;
        end
      end
      ST_LATCH: begin
        disp_d     = acc_q;
        disp_hex_d = hex_q;
        ovf_d      = sticky_q;
        done_d     = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign disp_o      = disp_q;
  assign disp_hex_o  = disp_hex_q;
  assign overflow_o  = ovf_q;
  assign conv_done_o = done_q;

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode seven-segment driver with BCD/hex conversion,
// leading-zero blanking and overflow dashes.
// Ports:
//   clk, rst    clock, async active-high reset
//   num         unsigned value to display
//   hex_mode    1 = hex digits, 0 = decimal
//   blank_lz    1 = blank leading zero digits (digit 0 always shown)
//   anode       active-low digit enables, MSB = leftmost digit
//   led_out     active-low segments {a,b,c,d,e,f,g}
//   overflow    last conversion did not fit in NUM_DIGITS digits
//   conv_done   one-cycle pulse when the display register updates
module seg7_scan_driver #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned BIN_W       = 13,
  parameter int unsigned REFRESH_DIV = 262144
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BIN_W-1:0]      num,
  input  logic                  hex_mode,
  input  logic                  blank_lz,
  output logic [NUM_DIGITS-1:0] anode,
  output logic [6:0]            led_out,
  output logic                  overflow,
  output logic                  conv_done
);
  import seg7_pkg::*;

  localparam int unsigned DISP_W = 4 * NUM_DIGITS;
  localparam int unsigned REF_W  = $clog2(REFRESH_DIV);
  localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [DISP_W-1:0]     disp;
  logic                  disp_hex;
  logic [REF_W-1:0]      ref_q, ref_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic [SEG_W-1:0]      led_q, led_d;
  logic [NUM_DIGITS-1:0] blank_dig;
  logic                  upper_zero;
  logic [NIB_W-1:0]      sel_nib;
  logic                  sel_blank;

  seq_bin2bcd #(
    .NUM_DIGITS (NUM_DIGITS),
    .BIN_W      (BIN_W)
  ) u_conv (
    .clk         (clk),
    .rst         (rst),
    .num_i       (num),
    .hex_mode_i  (hex_mode),
    .disp_o      (disp),
    .disp_hex_o  (disp_hex),
    .overflow_o  (overflow),
    .conv_done_o (conv_done)
  );

  // Refresh counter, scan index and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_q   <= '0;
      idx_q   <= IDX_W'(NUM_DIGITS - 1);
      anode_q <= '1;
      led_q   <= GLYPH_BLANK;
    end else begin
      ref_q   <= ref_d;
      idx_q   <= idx_d;
      anode_q <= anode_d;
      led_q   <= led_d;
    end
  end

  // Scan MSD first: index steps down on each refresh wrap.
  always_comb begin
    ref_d = ref_q + REF_W'(1);
    idx_d = idx_q;
    if (ref_q == REF_W'(REFRESH_DIV - 1)) begin
      ref_d = '0;
      idx_d = (idx_q == '0) ? IDX_W'(NUM_DIGITS - 1) : idx_q - IDX_W'(1);
    end
  end

  // A digit is blanked when it and every digit above it are zero.
  always_comb begin
    upper_zero = 1'b1;
    blank_dig  = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper_zero   = upper_zero & (disp[4*i +: 4] == 4'd0);
      blank_dig[i] = blank_lz & ~overflow & upper_zero & (i != 0);
    end
  end

  // Next anode/segment values for the active digit.
  always_comb begin
    sel_nib   = '0;
    sel_blank = 1'b0;
    anode_d   = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_nib    = disp[4*i +: 4];
        sel_blank  = blank_dig[i];
        anode_d[i] = blank_dig[i];
      end
    end
    if (overflow) begin
      led_d = GLYPH_DASH;
    end else if (sel_blank) begin
      led_d = GLYPH_BLANK;
    end else begin
      led_d = nib2glyph(sel_nib, disp_hex);
    end
  end

  assign anode   = anode_q;
  assign led_out = led_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench: a 4-digit and a 3-digit driver share clock and reset.
module tb_seg7_scan_driver;

  localparam logic [6:0] G0 = 7'b0000001, G1 = 7'b1001111, G2 = 7'b0010010;
  localparam logic [6:0] G3 = 7'b0000110, G4 = 7'b1001100, G5 = 7'b0100100;
  localparam logic [6:0] G6 = 7'b0100000, G7 = 7'b0001111, G8 = 7'b0000000;
  localparam logic [6:0] G9 = 7'b0000100, GA = 7'b0001000, GB = 7'b1100000;
  localparam logic [6:0] GC = 7'b0110001, GF = 7'b0111000;
  localparam logic [6:0] GD = 7'b1111110, GX = 7'b1111111;

  typedef struct {
    int         sel;
    logic [12:0] num;
    logic       hex;
    logic       blz;
    logic [3:0][6:0] glyph;
    logic [3:0] blank;
    logic       ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic [12:0] num0, num1;
  logic hex0, hex1, blz0, blz1;
  logic [3:0] an0;
  logic [2:0] an1;
  logic [6:0] led0, led1;
  logic ovf0, ovf1, done0, done1;

  int tests = 0;
  int fails = 0;

  vec_t tbl [13];
  vec_t v4321;
  vec_t sb_q [$];

  always #5 clk = ~clk;

  seg7_scan_driver #(.NUM_DIGITS(4), .BIN_W(13), .REFRESH_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .num(num0), .hex_mode(hex0), .blank_lz(blz0),
    .anode(an0), .led_out(led0), .overflow(ovf0), .conv_done(done0)
  );

  seg7_scan_driver #(.NUM_DIGITS(3), .BIN_W(13), .REFRESH_DIV(4)) dut3 (
    .clk(clk), .rst(rst), .num(num1), .hex_mode(hex1), .blank_lz(blz1),
    .anode(an1), .led_out(led1), .overflow(ovf1), .conv_done(done1)
  );

  function automatic logic [3:0] get_an(input int sel);
    return (sel == 0) ? an0 : {1'b1, an1};
  endfunction
  function automatic logic [6:0] get_led(input int sel);
    return (sel == 0) ? led0 : led1;
  endfunction
  function automatic logic get_ovf(input int sel);
    return (sel == 0) ? ovf0 : ovf1;
  endfunction
  function automatic logic get_done(input int sel);
    return (sel == 0) ? done0 : done1;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Advance to the next negedge with conv_done high, bounded.
  task automatic wait_done(input int sel, output int cycles, output bit ok);
    cycles = 0;
    ok = 1'b0;
    while (cycles < 64) begin
      @(negedge clk);
      cycles++;
      if (get_done(sel)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_done_chk(input int sel, input string tag);
    int c;
    bit ok;
    wait_done(sel, c, ok);
    if (!ok) chk({tag, " done_timeout"}, 32'(ok), 32'd1);
  endtask

  task automatic drive(input vec_t v);
    if (v.sel == 0) begin
      num0 = v.num; hex0 = v.hex; blz0 = v.blz;
    end else begin
      num1 = v.num; hex1 = v.hex; blz1 = v.blz;
    end
  endtask

  // Watch the scan for ncyc cycles and compare every active digit to v.
  task automatic check_frame(input vec_t v, input int ncyc, input string tag);
    logic [3:0] seen, bad, an;
    logic [6:0] led;
    logic [3:0][6:0] got;
    int illegal;
    bit found;
    seen = '0; bad = '0; illegal = 0; got = '0;
    repeat (ncyc) begin
      @(posedge clk);
      @(negedge clk);
      an  = get_an(v.sel);
      led = get_led(v.sel);
      if (an == 4'b1111) begin
        if (led !== GX) illegal++;
      end else begin
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
          if (an == ~(4'(1) << i)) begin
            found = 1'b1;
            seen[i] = 1'b1;
            if (!bad[i]) got[i] = led;
            if (led !== v.glyph[i]) bad[i] = 1'b1;
          end
        end
        if (!found) illegal++;
      end
    end
    chk({tag, " scan_legal"}, 32'(illegal), 32'd0);
    for (int i = 0; i < 4; i++) begin
      if (v.blank[i])
        chk($sformatf("%s d%0d_blanked_seen", tag, i), 32'(seen[i]), 32'd0);
      else
        chk($sformatf("%s d%0d_glyph", tag, i),
            seen[i] ? 32'(got[i]) : 32'hDEAD, 32'(v.glyph[i]));
    end
  endtask

  task automatic sb_check(input int ncyc, input string tag);
    vec_t e;
    chk({tag, " sb_nonempty"}, 32'(sb_q.size() > 0), 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({tag, " overflow"}, 32'(get_ovf(e.sel)), 32'(e.ovf));
      check_frame(e, ncyc, tag);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    bit ok;
    logic [3:0] exp_an;
    int d;

    tbl[0]  = '{0, 13'd1234,  1'b0, 1'b0, {G1, G2, G3, G4}, 4'b0000, 1'b0};
    tbl[1]  = '{0, 13'h1ABC,  1'b1, 1'b0, {G1, GA, GB, GC}, 4'b0000, 1'b0};
    tbl[2]  = '{0, 13'd7,     1'b0, 1'b1, {GX, GX, GX, G7}, 4'b1110, 1'b0};
    tbl[3]  = '{0, 13'd0,     1'b0, 1'b1, {GX, GX, GX, G0}, 4'b1110, 1'b0};
    tbl[4]  = '{0, 13'd0,     1'b0, 1'b0, {G0, G0, G0, G0}, 4'b0000, 1'b0};
    tbl[5]  = '{0, 13'd8191,  1'b0, 1'b0, {G8, G1, G9, G1}, 4'b0000, 1'b0};
    tbl[6]  = '{0, 13'h0F0,   1'b1, 1'b1, {GX, GX, GF, G0}, 4'b1100, 1'b0};
    tbl[7]  = '{0, 13'd5060,  1'b0, 1'b1, {G5, G0, G6, G0}, 4'b0000, 1'b0};
    tbl[8]  = '{1, 13'd1234,  1'b0, 1'b0, {GX, GD, GD, GD}, 4'b1000, 1'b1};
    tbl[9]  = '{1, 13'd999,   1'b0, 1'b0, {GX, G9, G9, G9}, 4'b1000, 1'b0};
    tbl[10] = '{1, 13'h1ABC,  1'b1, 1'b1, {GX, GD, GD, GD}, 4'b1000, 1'b1};
    tbl[11] = '{1, 13'd42,    1'b0, 1'b1, {GX, GX, G4, G2}, 4'b1100, 1'b0};
    tbl[12] = '{1, 13'hFFF,   1'b1, 1'b0, {GX, GF, GF, GF}, 4'b1000, 1'b0};
    v4321   = '{0, 13'd4321,  1'b0, 1'b0, {G4, G3, G2, G1}, 4'b0000, 1'b0};

    rst = 1'b1;
    num0 = 13'd1234; hex0 = 1'b0; blz0 = 1'b0;
    num1 = 13'd0;    hex1 = 1'b0; blz1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset anode4", 32'(an0), 32'hF);
    chk("reset led4", 32'(led0), 32'h7F);
    chk("reset ovf4", 32'(ovf0), 32'd0);
    chk("reset done4", 32'(done0), 32'd0);
    chk("reset anode3", 32'(an1), 32'h7);

    // Reset release, first conversion latency and exact MSD-first scan order.
    rst = 1'b0;
    wait_done(0, c, ok);
    chk("first_done_latency", ok ? 32'(c) : 32'hFFFF, 32'd15);
    @(posedge clk);
    for (int k = 0; k < 16; k++) begin
      @(posedge clk);
      @(negedge clk);
      d = 3 - (k / 4);
      exp_an = ~(4'(1) << d);
      chk($sformatf("scan%0d anode", k), 32'(an0), 32'(exp_an));
      chk($sformatf("scan%0d led", k), 32'(led0), 32'(tbl[0].glyph[d]));
    end

    // Table vectors through the scoreboard.
    for (int t = 0; t < 13; t++) begin
      wait_done_chk(tbl[t].sel, $sformatf("vec%0d pre", t));
      drive(tbl[t]);
      sb_q.push_back(tbl[t]);
      wait_done_chk(tbl[t].sel, $sformatf("vec%0d", t));
      sb_check((tbl[t].sel == 0) ? 16 : 12, $sformatf("vec%0d", t));
    end

    // Input change mid-SHIFT is ignored until the next capture.
    wait_done_chk(0, "stale pre");
    drive(tbl[0]);
    sb_q.push_back(tbl[0]);
    repeat (3) @(posedge clk);
    @(negedge clk);
    num0 = 13'd4321;
    sb_q.push_back(v4321);
    wait_done_chk(0, "stale first");
    sb_check(14, "stale first");
    wait_done_chk(0, "stale second");
    sb_check(16, "stale second");

    // One-cycle reset mid-SHIFT while the 3-digit unit shows overflow.
    wait_done_chk(0, "rst pre");
    num1 = 13'd1234; hex1 = 1'b0; blz1 = 1'b0;
    wait_done_chk(0, "rst ovf");
    chk("pre-reset ovf3", 32'(ovf1), 32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst anode4", 32'(an0), 32'hF);
    chk("midrst led4", 32'(led0), 32'h7F);
    chk("midrst done4", 32'(done0), 32'd0);
    chk("midrst anode3", 32'(an1), 32'h7);
    chk("midrst ovf3", 32'(ovf1), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_done(0, c, ok);
    chk("post-reset latency", ok ? 32'(c) : 32'hFFFF, 32'd15);
    chk("post-reset done3", 32'(done1), 32'd1);
    chk("post-reset ovf3", 32'(ovf1), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Parametrised multiplexed seven-segment display driver. It is the successor to the fixed 4-digit, 13-bit decimal driver.
- Converts a binary value to BCD or hex digits with a sequential shift-add-3 engine, so there are no wide combinational divide/modulo paths.
- Scans N common-anode digits, with optional leading-zero blanking and overflow indication.
- Sits between the processor's debug/IO register and the board's anode and segment pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (1..8)
BIN_W, 13, width of the binary input value (1..32)
REFRESH_DIV, 262144, clk cycles each digit stays active (>=2); benches use 4

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
num  in  BIN_W  unsigned value to display
hex_mode  in  1  1 = hexadecimal digits, 0 = decimal
blank_lz  in  1  1 = blank leading zero digits
anode  out  NUM_DIGITS  active-low digit enables; bit NUM_DIGITS-1 = most significant (leftmost) digit
led_out  out  7  active-low segments {a,b,c,d,e,f,g}; "0" = 7'b0000001
overflow  out  1  value of the last conversion does not fit in NUM_DIGITS digits
conv_done  out  1  one-cycle pulse when the display register updates

Behaviour:
- Reset (async, active-high) values:
  - anode = all 1s; led_out = 7'b1111111; overflow = 0; conv_done = 0.
  - Display register = 0; conversion FSM = IDLE; refresh counter = 0; scan index = NUM_DIGITS-1.
- Conversion FSM (continuous reconversion):
  - IDLE: capture num and hex_mode into the shift register; clear the BCD accumulator (4*NUM_DIGITS bits) and the overflow sticky bit. Go to SHIFT.
  - SHIFT: BIN_W cycles. Each cycle, in decimal mode add 3 to every BCD nibble >=5, then shift left one bit with the next binary MSB entering the accumulator LSB. Hex mode skips the add-3 step. Any 1 shifted out of the accumulator MSB sets the sticky overflow bit. Go to LATCH after the BIN_W-th shift.
  - LATCH: copy the accumulator to the display register and the sticky bit to overflow; pulse conv_done. Go to IDLE.
  - Capture to conv_done takes exactly BIN_W+2 cycles. The display register changes atomically, so no torn digits.
  - num and hex_mode changes during SHIFT/LATCH are ignored until the next IDLE capture.
- Scan:
  - The refresh counter counts 0..REFRESH_DIV-1. On wrap, the scan index decrements; at 0 it wraps to NUM_DIGITS-1, giving MSD-first order.
  - anode and led_out are registered: they reflect the scan index and display register one cycle after either changes.
  - Active digit: its anode bit = 0, all others = 1.
- Glyphs:
  - Digits 0-9 use the standard active-low table.
  - Hex letters: A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
  - A nibble >9 in decimal mode cannot occur; the decoder maps it to "0".
- Overflow: while overflow=1, every digit shows a dash (7'b1111110) and blanking is ignored.
- Leading-zero blanking: when blank_lz=1, digits above the highest nonzero digit have their anode bit held at 1 and led_out=1111111. Digit 0 is never blanked, so value 0 shows a single "0".
- Reset mid-conversion: everything returns to reset values immediately. The first conversion after release starts on the first clk edge with rst=0.

Decomposition:
- Package seg7_pkg:
  - Constants: the 7-bit glyph values (0-F, DASH, BLANK).
  - Function: nibble-to-glyph decode.
  - Typedef: the conversion state enum (IDLE, SHIFT, LATCH).
- Sub-module seq_bin2bcd: the sequential shift-add-3 converter, including hex bypass, overflow and conv_done.
- The top level holds the refresh counter, scan index, blanking and the output registers.

Test Plan:
- NUM_DIGITS=4, BIN_W=13, REFRESH_DIV=4, num=1234, decimal, blank_lz=0 -> conv_done 15 cycles after reset release. Scan sequence: anode 0111/1001111, 1011/0010010, 1101/0000110, 1110/1001100, each held 4 cycles, then repeating.
- num=13'h1ABC, hex_mode=1 -> digits 1, A, b, C; overflow=0.
- NUM_DIGITS=3, num=1234, decimal -> overflow=1; all three digits show 1111110. Then num=999 -> overflow=0 and 9,9,9 after the next conv_done.
- num=7, blank_lz=1 -> anodes 3..1 never low; digit 0 shows 0001111. Then num=0 -> only digit 0 shows 0000001.
- num changes 1234->4321 in the 3rd SHIFT cycle -> next conv_done displays 1234; the following conv_done displays 4321; no mixed digits in between.
- Assert rst for 1 cycle mid-SHIFT and mid-scan -> anode all 1s and led_out 1111111 in the same cycle. After release, a conversion restarts and conv_done fires after BIN_W+2 cycles.
